// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues ready-handshake fetches, and drives the
// IF/ID register. A one-entry skid buffer absorbs decode stalls; redirects drop wrong-path responses.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectAddr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCAddrIncOut,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pcinc;
  logic        r_skid_valid;
  logic        r_imem_req;
  logic [31:0] r_instr;
  logic [31:0] r_pcinc;
  logic        r_valid;

  logic [31:0] w_redirect_target;
  logic [31:0] w_pc_inc;

  assign w_redirect_target = {RedirectAddr[31:2], 2'b00};
  assign w_pc_inc          = r_pc + 32'd4;

  assign IMemReq      = r_imem_req;
  assign IMemAddr     = r_pc;
  assign Instruction  = r_instr;
  assign PCAddrIncOut = r_pcinc;
  assign InstrValid   = r_valid;

  // NOTE: every state element, including buffer data and the pending target, is reset so that
  // a mid-operation reset leaves no trace of the earlier program flow.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_VECTOR;
      r_pending    <= RESET_VECTOR;
      r_skid_instr <= NOP_INSTR;
      r_skid_pcinc <= 32'd0;
      r_skid_valid <= 1'b0;
      r_imem_req   <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pcinc      <= 32'd0;
      r_valid      <= 1'b0;
    end else begin
      // Redirect flush applies in every state, regardless of Stall.
      if (RedirectValid) begin
        r_valid      <= 1'b0;
        r_instr      <= NOP_INSTR;
        r_skid_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
          if (RedirectValid) begin
            r_pc <= w_redirect_target;
          end
        end

        REQ: begin
          if (RedirectValid) begin
            if (IMemReady) begin
              r_pc <= w_redirect_target;
            end else begin
              // Address must not change mid-request; park the target until the old fetch completes.
              r_pending <= w_redirect_target;
              r_state   <= DROP;
            end
          end else if (IMemReady) begin
            r_pc <= w_pc_inc;
            if (!Stall) begin
              r_instr <= IMemData;
              r_pcinc <= w_pc_inc;
              r_valid <= 1'b1;
            end else begin
              r_skid_instr <= IMemData;
              r_skid_pcinc <= w_pc_inc;
              r_skid_valid <= 1'b1;
              r_state      <= HOLD;
              r_imem_req   <= 1'b0;
            end
          end else if (!Stall) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
          end
        end

        HOLD: begin
          if (RedirectValid) begin
            r_pc       <= w_redirect_target;
            r_state    <= REQ;
            r_imem_req <= 1'b1;
          end else if (!Stall && r_skid_valid) begin
            r_instr      <= r_skid_instr;
            r_pcinc      <= r_skid_pcinc;
            r_valid      <= 1'b1;
            r_skid_valid <= 1'b0;
            r_state      <= REQ;
            r_imem_req   <= 1'b1;
          end
        end

        DROP: begin
          if (RedirectValid) begin
            if (IMemReady) begin
              r_pc    <= w_redirect_target;
              r_state <= REQ;
            end else begin
              r_pending <= w_redirect_target;
            end
          end else if (IMemReady) begin
            r_pc    <= r_pending;
            r_state <= REQ;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_addr_aligned : assert property (@(posedge Clock) disable iff (Reset)
    IMemReq |-> (IMemAddr[1:0] == 2'b00));

  a_addr_stable : assert property (@(posedge Clock) disable iff (Reset)
    (IMemReq && !IMemReady) |=> (IMemAddr == $past(IMemAddr)));

  a_skid_in_hold : assert property (@(posedge Clock) disable iff (Reset)
    r_skid_valid == (r_state == HOLD));

  a_no_req_in_hold : assert property (@(posedge Clock) disable iff (Reset)
    (r_state == HOLD || r_state == IDLE) |-> !IMemReq);
`endif

endmodule
